float_threshold_search: RTL

//  Initiator side of the float comparator interface: drives candidate IEEE-754

---
 rtl/float_threshold_search.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/float_threshold_search.sv
// Successive-approximation readback of a float comparator threshold: probes `a`,
// reads `is_higher`, recovers b. Optional `abort` input when FTS_ABORT_EN is defined.
module float_threshold_search #(
   parameter int CMP_LATENCY = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
`ifdef FTS_ABORT_EN
   input  logic        abort,
`endif
   output logic [31:0] a,
   input  logic        is_higher,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        sat_low,
   output logic        sat_high
);

   localparam int WCNT_W = (CMP_LATENCY < 2) ? 1 : $clog2(CMP_LATENCY + 1);
   localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(CMP_LATENCY);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Ordered key to float bits: keys above 2^31 are non-negative floats, the rest are
   // negatives in reversed order, so the key space is monotone in float value.
   function automatic logic [31:0] key_to_float(input logic [31:0] k);
      return k[31] ? {1'b0, k[30:0]} : ~k;
   endfunction

   state_t             state_r, state_s;
   logic [31:0]        acc_r, acc_s;
   logic [4:0]         bit_r, bit_s;
   logic [WCNT_W-1:0]  wcnt_r, wcnt_s;
   logic [31:0]        a_r, a_s;
   logic               busy_r, busy_s;
   logic               done_r, done_s;
   logic [31:0]        result_r, result_s;
   logic               sat_low_r, sat_low_s;
   logic               sat_high_r, sat_high_s;
   logic               abort_s;
   logic               sample_s;
   logic [31:0]        acc_upd_s;
   logic [4:0]         bit_dec_s;

`ifdef FTS_ABORT_EN
   assign abort_s = abort;
`else
   assign abort_s = 1'b0;
`endif

   assign sample_s  = (state_r == ST_WAIT) && (wcnt_r == '0) && !abort_s;
   assign acc_upd_s = is_higher ? acc_r : (acc_r | (32'd1 << bit_r));
   assign bit_dec_s = bit_r - 5'd1;

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode; abort outranks the probe sample.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_s = ST_WAIT;
            else       state_s = ST_IDLE;
         end
         ST_WAIT: begin
            if (abort_s)                        state_s = ST_IDLE;
            else if (sample_s && bit_r == 5'd0) state_s = ST_DONE;
            else                                state_s = ST_WAIT;
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Datapath next values; every output is registered from these.
   always_comb begin
      acc_s      = acc_r;
      bit_s      = bit_r;
      wcnt_s     = wcnt_r;
      a_s        = a_r;
      busy_s     = busy_r;
      done_s     = 1'b0;
      result_s   = result_r;
      sat_low_s  = sat_low_r;
      sat_high_s = sat_high_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               a_s    = key_to_float(32'h8000_0000);
               acc_s  = 32'h0000_0000;
               bit_s  = 5'd31;
               wcnt_s = WCNT_LOAD;
               busy_s = 1'b1;
            end else begin
               busy_s = 1'b0;
            end
         end
         ST_WAIT: begin
            if (abort_s) begin
               busy_s = 1'b0;
            end else if (wcnt_r != '0) begin
               wcnt_s = wcnt_r - WCNT_W'(1);
            end else begin
               acc_s = acc_upd_s;
               if (bit_r != 5'd0) begin
                  bit_s  = bit_dec_s;
                  a_s    = key_to_float(acc_upd_s | (32'd1 << bit_dec_s));
                  wcnt_s = WCNT_LOAD;
               end else begin
                  busy_s     = 1'b0;
                  done_s     = 1'b1;
                  result_s   = key_to_float(acc_upd_s);
                  sat_low_s  = (acc_upd_s == 32'h0000_0000);
                  sat_high_s = (acc_upd_s == 32'hFFFF_FFFF);
               end
            end
         end
         ST_DONE: begin
            busy_s = 1'b0;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc_r      <= 32'h0000_0000;
         bit_r      <= 5'd31;
         wcnt_r     <= '0;
         a_r        <= 32'h0000_0000;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         result_r   <= 32'h0000_0000;
         sat_low_r  <= 1'b0;
         sat_high_r <= 1'b0;
      end else begin
         acc_r      <= acc_s;
         bit_r      <= bit_s;
         wcnt_r     <= wcnt_s;
         a_r        <= a_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
         result_r   <= result_s;
         sat_low_r  <= sat_low_s;
         sat_high_r <= sat_high_s;
      end
   end

   assign a        = a_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign result   = result_r;
   assign sat_low  = sat_low_r;
   assign sat_high = sat_high_r;

endmodule
